// File: rtl/bitplay.sv
// Pattern generator: replays stored run lengths as a toggling 1-bit waveform.
// Define BITPLAY_LOOP_EN to add the loop input for continuous replay.
module bitplay #(
  parameter int ADDR_WIDTH   = 9,
  parameter int LENGTH_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    writeEnable,
  input  logic [ADDR_WIDTH-1:0]   writeIndex,
  input  logic [LENGTH_WIDTH-1:0] writeData,
  input  logic                    start,
  input  logic                    stop,
  input  logic [ADDR_WIDTH:0]     count,
  input  logic                    startLevel,
  output logic                    bitOut,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              debugState
`ifdef BITPLAY_LOOP_EN
  ,
  input  logic                    loop
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, RUN = 2'd2} state_t;

  state_t state, nextState;

  logic [LENGTH_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [LENGTH_WIDTH-1:0] rdData;
  logic [LENGTH_WIDTH-1:0] counter;
  logic [ADDR_WIDTH:0]     countLat;
  logic [ADDR_WIDTH:0]     playNum;
  logic [ADDR_WIDTH:0]     loadNum;
  logic                    levelLat;
  logic                    loopLat;
  logic                    loopIn;
  logic                    rdEn;
  logic [ADDR_WIDTH-1:0]   rdAddr;
  logic                    acceptStart;
  logic                    emptyStart;
  logic                    loadEntry;
  logic                    wrapLoop;
  logic                    finish;
  logic                    abort;

`ifdef BITPLAY_LOOP_EN
  assign loopIn = loop;
`else
  assign loopIn = 1'b0;
`endif

  assign debugState = state;

  // Handshake: start is a one-cycle request honoured only in IDLE; stop
  // aborts FETCH/RUN and takes priority over start.
  always_comb begin
    nextState   = state;
    acceptStart = 1'b0;
    emptyStart  = 1'b0;
    loadEntry   = 1'b0;
    wrapLoop    = 1'b0;
    finish      = 1'b0;
    abort       = 1'b0;
    loadNum     = playNum + 1'b1;
    rdEn        = 1'b0;
    rdAddr      = '0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          if (count == '0) begin
            emptyStart = 1'b1;
          end else begin
            acceptStart = 1'b1;
            rdEn        = 1'b1;
            nextState   = FETCH;
          end
        end
      end
      FETCH: begin
        if (stop) begin
          abort     = 1'b1;
          nextState = IDLE;
        end else begin
          loadEntry = 1'b1;
          loadNum   = (ADDR_WIDTH+1)'(1);
          nextState = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          abort     = 1'b1;
          nextState = IDLE;
        end else if (counter == '0) begin
          if (playNum != countLat) begin
            loadEntry = 1'b1;
          end else if (loopLat) begin
            loadEntry = 1'b1;
            wrapLoop  = 1'b1;
            loadNum   = (ADDR_WIDTH+1)'(1);
          end else begin
            finish    = 1'b1;
            nextState = IDLE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
    // Prefetch the entry after the one being loaded; in loop mode the
    // entry after the last one is entry 0.
    if (loadEntry) begin
      rdEn   = 1'b1;
      rdAddr = (loopLat && loadNum == countLat) ? '0 : loadNum[ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Run-length memory: not reset, bus writes dropped during playback.
  always_ff @(posedge clk) begin
    if (writeEnable && !busy) mem[writeIndex] <= writeData;
    if (rdEn) rdData <= mem[rdAddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bitOut   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      counter  <= '0;
      playNum  <= '0;
      countLat <= '0;
      levelLat <= 1'b0;
      loopLat  <= 1'b0;
    end else begin
      done <= emptyStart | finish;
      if (acceptStart) begin
        countLat <= count;
        levelLat <= startLevel;
        loopLat  <= loopIn;
        busy     <= 1'b1;
        playNum  <= '0;
      end
      if (loadEntry) begin
        counter <= rdData;
        playNum <= loadNum;
        bitOut  <= (state == FETCH || wrapLoop) ? levelLat : ~bitOut;
      end else if (state == RUN && counter != '0 && !stop) begin
        counter <= counter - 1'b1;
      end
      if (finish || abort) begin
        bitOut  <= 1'b0;
        busy    <= 1'b0;
        counter <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bitplay.sv
// Directed bench for bitplay: hand-computed waveforms checked cycle by cycle.
module tb_bitplay;
  localparam int AW = 9;
  localparam int LW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          writeEnable;
  logic [AW-1:0] writeIndex;
  logic [LW-1:0] writeData;
  logic          start;
  logic          stop;
  logic [AW:0]   count;
  logic          startLevel;
  logic          bitOut;
  logic          busy;
  logic          done;
  logic [1:0]    debugState;
`ifdef BITPLAY_LOOP_EN
  logic          loop;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bitplay #(.ADDR_WIDTH(AW), .LENGTH_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .writeEnable(writeEnable), .writeIndex(writeIndex),
    .writeData(writeData), .start(start), .stop(stop), .count(count),
    .startLevel(startLevel), .bitOut(bitOut), .busy(busy), .done(done),
    .debugState(debugState)
`ifdef BITPLAY_LOOP_EN
    , .loop(loop)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] idx, input logic [LW-1:0] val);
    writeEnable = 1'b1;
    writeIndex  = idx;
    writeData   = val;
    tick();
    writeEnable = 1'b0;
  endtask

  task automatic go(input logic [AW:0] n, input logic lvl);
    count      = n;
    startLevel = lvl;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Vectors read left to right in time: the MSB of the n-bit field is the
  // value after the first tick.
  task automatic playCheck(input string tag, input int n, input logic [31:0] bits,
                           input logic [31:0] bz, input logic [31:0] dn);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s.bitOut[%0d]", tag, i), 32'(bitOut), 32'(bits[n-1-i]));
      chk($sformatf("%s.busy[%0d]", tag, i), 32'(busy), 32'(bz[n-1-i]));
      chk($sformatf("%s.done[%0d]", tag, i), 32'(done), 32'(dn[n-1-i]));
    end
  endtask

  initial begin
    reset = 1'b1; writeEnable = 1'b0; writeIndex = '0; writeData = '0;
    start = 1'b0; stop = 1'b0; count = '0; startLevel = 1'b0;
`ifdef BITPLAY_LOOP_EN
    loop = 1'b0;
`endif
    tick();
    tick();
    chk("reset.bitOut", 32'(bitOut), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.state", 32'(debugState), 32'd0);
    reset = 1'b0;
    tick();

    // Entries {3,0,1}, level 0: 0000 1 00, busy 8 cycles, single done.
    wr(0, 3); wr(1, 0); wr(2, 1);
    go(3, 0);
    chk("t1.busyAfterStart", 32'(busy), 32'd1);
    chk("t1.stateFetch", 32'(debugState), 32'd1);
    chk("t1.bitAfterStart", 32'(bitOut), 32'd0);
    playCheck("t1", 9, 32'b000010000, 32'b111111100, 32'b000000010);

    // Four 1-cycle runs starting high: no bubble between runs.
    wr(0, 0); wr(1, 0); wr(2, 0); wr(3, 0);
    go(4, 1);
    playCheck("t2", 6, 32'b101000, 32'b111100, 32'b000010);

    // count=0: done next cycle, never busy.
    go(0, 0);
    chk("t3.busy", 32'(busy), 32'd0);
    chk("t3.done", 32'(done), 32'd1);
    chk("t3.bitOut", 32'(bitOut), 32'd0);
    tick();
    chk("t3.doneOnce", 32'(done), 32'd0);

    // stop together with start in IDLE: start ignored.
    stop = 1'b1;
    go(3, 0);
    stop = 1'b0;
    chk("stopWins.busy", 32'(busy), 32'd0);
    chk("stopWins.state", 32'(debugState), 32'd0);
    tick();
    chk("stopWins.done", 32'(done), 32'd0);

    // Long run aborted by stop; start while busy ignored.
    wr(0, 1000);
    go(1, 1);
    playCheck("t4", 9, 32'h1FF, 32'h1FF, 32'h000);
    count = '0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4.startWhileBusy.busy", 32'(busy), 32'd1);
    tick();
    chk("t4.startWhileBusy.done", 32'(done), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4.stop.bitOut", 32'(bitOut), 32'd0);
    chk("t4.stop.busy", 32'(busy), 32'd0);
    chk("t4.stop.state", 32'(debugState), 32'd0);
    tick();
    chk("t4.stop.noDone", 32'(done), 32'd0);
    go(1, 1);
    tick();
    chk("t4.replay.bitOut", 32'(bitOut), 32'd1);
    chk("t4.replay.state", 32'(debugState), 32'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Write during playback dropped: run 1 stays 3 cycles.
    wr(0, 1); wr(1, 2); wr(2, 0);
    go(3, 0);
    writeEnable = 1'b1; writeIndex = 1; writeData = 5;
    playCheck("t5", 6, 32'b001110, 32'b111111, 32'b000000);
    writeEnable = 1'b0;
    playCheck("t5end", 2, 32'b00, 32'b00, 32'b10);

    // Reset mid-run, then the memory still holds {1,2,0}.
    go(3, 0);
    tick(); tick(); tick();
    chk("t6.midRun.bitOut", 32'(bitOut), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6.reset.bitOut", 32'(bitOut), 32'd0);
    chk("t6.reset.busy", 32'(busy), 32'd0);
    chk("t6.reset.state", 32'(debugState), 32'd0);
    go(3, 0);
    playCheck("t6replay", 8, 32'b00111000, 32'b11111100, 32'b00000010);

`ifdef BITPLAY_LOOP_EN
    // Loop of {1,2} from level 1: 11000 repeating, no done.
    wr(0, 1); wr(1, 2);
    loop = 1'b1;
    go(2, 1);
    loop = 1'b0;
    playCheck("loop", 15, 32'b110001100011000, 32'h7FFF, 32'h0000);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("loop.stop.busy", 32'(busy), 32'd0);
    chk("loop.stop.bitOut", 32'(bitOut), 32'd0);
    tick();
    chk("loop.stop.done", 32'(done), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
